// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types for the FIFO drain packer.
//   STATE_W : width of the drain FSM state encoding
//   state_e : drain FSM states (IDLE=0, FILL=1, WRITE=2, DONE=3)
package fifo_drain_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_drain_packer_if.sv
// fifo_drain_packer_if: control, FIFO read and SRAM write signals of the drain packer.
//   start/len/base_addr : drain request from the core controller
//   fifo_out/fifo_empty : FIFO head entry and empty flag; fifo_rd pops it
//   mem_we/mem_addr/mem_d : SRAM write port
//   busy/done : status back to the controller
// Modport master is the packer, slave is its environment.
interface fifo_drain_packer_if #(
    parameter int unsigned bw     = 4,
    parameter int unsigned simd   = 1,
    parameter int unsigned pack   = 4,
    parameter int unsigned addr_w = 11
) ();

    localparam int unsigned E = simd * bw;
    localparam int unsigned W = pack * E;

    logic              start;
    logic [addr_w:0]   len;
    logic [addr_w-1:0] base_addr;
    logic [E-1:0]      fifo_out;
    logic              fifo_empty;
    logic              fifo_rd;
    logic              mem_we;
    logic [addr_w-1:0] mem_addr;
    logic [W-1:0]      mem_d;
    logic              busy;
    logic              done;

    modport master (
        input  start, len, base_addr, fifo_out, fifo_empty,
        output fifo_rd, mem_we, mem_addr, mem_d, busy, done
    );

    modport slave (
        output start, len, base_addr, fifo_out, fifo_empty,
        input  fifo_rd, mem_we, mem_addr, mem_d, busy, done
    );

endinterface

// File: rtl/fifo_drain_packer_relu_lane.sv
// drain_relu_lane: clamps one two's-complement lane to zero when negative.
//   lane_i : bw-bit signed lane in
//   lane_o : lane_i if non-negative, else 0
// Only compiled when FIFO_DRAIN_RELU_EN is defined.
`ifdef FIFO_DRAIN_RELU_EN
module drain_relu_lane #(
    parameter int unsigned bw = 4
) (
    input  logic [bw-1:0] lane_i,
    output logic [bw-1:0] lane_o
);

    assign lane_o = lane_i[bw-1] ? '0 : lane_i;

endmodule
`endif

// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer: pops FIFO entries, packs `pack` of them per SRAM word and
// writes `len` words from base_addr upward, then pulses done.
//   rd_clk : clock (FIFO read side)
//   reset  : synchronous, active-high
//   bus    : fifo_drain_packer_if.master (control, FIFO read, SRAM write, status)
// Macro FIFO_DRAIN_RELU_EN: clamp negative lanes to zero on capture.
module fifo_drain_packer
    import fifo_drain_pkg::*;
#(
    parameter int unsigned bw     = 4,
    parameter int unsigned simd   = 1,
    parameter int unsigned pack   = 4,
    parameter int unsigned addr_w = 11
) (
    input  logic rd_clk,
    input  logic reset,
    fifo_drain_packer_if.master bus
);

    localparam int unsigned E      = simd * bw;
    localparam int unsigned W      = pack * E;
    localparam int unsigned CNT_W  = addr_w + 1;
    localparam int unsigned SLOT_W = (pack > 1) ? $clog2(pack) : 1;

    state_e             state_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [CNT_W-1:0]   word_q;
    logic [CNT_W-1:0]   len_q;
    logic [addr_w-1:0]  base_q;
    logic [addr_w-1:0]  addr_q;
    logic [W-1:0]       pack_q;
    logic [W-1:0]       mem_d_q;
    logic               we_q;
    logic               busy_q;
    logic               done_q;

    logic [E-1:0]       entry_c;
    logic [W-1:0]       pack_c;
    logic               pop_c;
    logic               last_slot_c;
    logic               last_word_c;

    // Per-lane conditioning of the FIFO head entry
`ifdef FIFO_DRAIN_RELU_EN
    for (genvar l = 0; l < simd; l++) begin : g_relu
        drain_relu_lane #(.bw(bw)) u_lane (
            .lane_i (bus.fifo_out[l*bw +: bw]),
            .lane_o (entry_c[l*bw +: bw])
        );
    end
`else
    assign entry_c = bus.fifo_out;
`endif

    // Packed word with the current entry merged into slot slot_q
    always_comb begin
        pack_c = pack_q;
        for (int k = 0; k < pack; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                pack_c[k*E +: E] = entry_c;
            end
        end
    end

    assign pop_c       = (state_q == FILL) && !bus.fifo_empty;
    assign last_slot_c = (slot_q == SLOT_W'(pack - 1));
    assign last_word_c = (CNT_W'(word_q + 1'b1) == len_q);

    // Drain FSM with registered SRAM and status outputs
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= '0;
            word_q  <= '0;
            len_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            pack_q  <= '0;
            mem_d_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        len_q  <= bus.len;
                        base_q <= bus.base_addr;
                        slot_q <= '0;
                        word_q <= '0;
                        busy_q <= 1'b1;
                        if (bus.len == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (pop_c) begin
                        pack_q <= pack_c;
                        if (last_slot_c) begin
                            // Launch the write so mem_we is high during WRITE
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                            mem_d_q <= pack_c;
                            addr_q  <= base_q + addr_w'(word_q);
                            slot_q  <= '0;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_q <= word_q + 1'b1;
                    slot_q <= '0;
                    if (last_word_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= FILL;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd  = pop_c;
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_d    = mem_d_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb_fifo_drain_packer: directed bench for fifo_drain_packer with a queue FIFO model.
module tb_fifo_drain_packer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_drain_packer_if #(.bw(4), .simd(1), .pack(4), .addr_w(11)) ifc ();

    fifo_drain_packer #(.bw(4), .simd(1), .pack(4), .addr_w(11)) dut (
        .rd_clk (clk),
        .reset  (reset),
        .bus    (ifc)
    );

    typedef struct {
        logic [10:0] a;
        logic [15:0] d;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  fq[$];
    bit          gate      = 1'b0;
    bit          toggle_en = 1'b0;
    int          pop_cnt   = 0;
    int          viol_cnt  = 0;
    wr_t         wq[$];

    task automatic refresh();
        ifc.fifo_empty = (fq.size() == 0) || gate;
        ifc.fifo_out   = (fq.size() != 0) ? fq[0] : 4'h0;
    endtask

    // FIFO model: pop on fifo_rd, optional empty gating every other cycle
    always begin
        @(posedge clk);
        if (ifc.fifo_rd && fq.size() > 0) void'(fq.pop_front());
        if (toggle_en) gate = ~gate;
        #1;
        refresh();
    end

    // Monitor
    always @(negedge clk) begin
        if (ifc.fifo_rd) pop_cnt++;
        if (ifc.fifo_rd && ifc.fifo_empty) viol_cnt++;
        if (ifc.mem_we) wq.push_back('{ifc.mem_addr, ifc.mem_d});
    end

    task automatic clear_mon();
        pop_cnt  = 0;
        viol_cnt = 0;
        wq.delete();
    endtask

    task automatic preload(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(4'(first + i));
        refresh();
    endtask

    task automatic do_start(input logic [11:0] len, input logic [10:0] base);
        @(negedge clk);
        ifc.start     = 1'b1;
        ifc.len       = len;
        ifc.base_addr = base;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    // Cycle index (1 = cycle after the start edge) at which done is seen; 0 on timeout
    task automatic wait_done(output int cyc, output logic busy1);
        cyc   = 0;
        busy1 = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) busy1 = ifc.busy;
            if (ifc.done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (ifc.fifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rd got %b want 0", ifc.fifo_rd); end
        n_checks++; if (ifc.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", ifc.mem_we); end
        n_checks++; if (ifc.mem_addr !== 11'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", ifc.mem_addr); end
        n_checks++; if (ifc.mem_d !== 16'h0) begin n_fail++; $display("FAIL reset_mem_d got %h want 0", ifc.mem_d); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        n_checks++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", ifc.done); end
    endtask

    task automatic test_basic();
        int cyc; logic b1;
        logic [10:0] ea[2]; logic [15:0] ed[2];
        ea[0] = 11'h010; ed[0] = 16'h4321;
        ea[1] = 11'h011; ed[1] = 16'h8765;
        clear_mon();
        preload(1, 8);
        do_start(12'd2, 11'h010);
        wait_done(cyc, b1);
        n_checks++; if (cyc !== 11) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 11", cyc); end
        n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_first got %b want 1", b1); end
        n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_done got %b want 1", ifc.busy); end
        n_checks++; if (wq.size() !== 2) begin n_fail++; $display("FAIL basic_write_count got %0d want 2", wq.size()); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (k >= wq.size() || wq[k].a !== ea[k] || wq[k].d !== ed[k]) begin
                n_fail++;
                $display("FAIL basic_write%0d got addr %h data %h want addr %h data %h",
                         k, (k < wq.size()) ? wq[k].a : 11'h0, (k < wq.size()) ? wq[k].d : 16'h0, ea[k], ed[k]);
            end
        end
        n_checks++; if (pop_cnt !== 8) begin n_fail++; $display("FAIL basic_pops got %0d want 8", pop_cnt); end
        @(negedge clk);
        n_checks++; if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin n_fail++; $display("FAIL basic_idle got busy %b done %b want 0 0", ifc.busy, ifc.done); end
        n_checks++; if (ifc.mem_d !== 16'h8765) begin n_fail++; $display("FAIL basic_mem_d_held got %h want 8765", ifc.mem_d); end
    endtask

    task automatic test_stall();
        int cyc; logic b1;
        logic [10:0] ea[2]; logic [15:0] ed[2];
        ea[0] = 11'h020; ed[0] = 16'h4321;
        ea[1] = 11'h021; ed[1] = 16'h8765;
        clear_mon();
        toggle_en = 1'b1;
        preload(1, 8);
        do_start(12'd2, 11'h020);
        wait_done(cyc, b1);
        toggle_en = 1'b0;
        gate = 1'b0;
        refresh();
        n_checks++; if (cyc <= 11) begin n_fail++; $display("FAIL stall_done_cycle got %0d want >11", cyc); end
        n_checks++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL stall_pop_while_empty got %0d want 0", viol_cnt); end
        n_checks++; if (pop_cnt !== 8) begin n_fail++; $display("FAIL stall_pops got %0d want 8", pop_cnt); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (k >= wq.size() || wq[k].a !== ea[k] || wq[k].d !== ed[k]) begin
                n_fail++;
                $display("FAIL stall_write%0d got addr %h data %h want addr %h data %h",
                         k, (k < wq.size()) ? wq[k].a : 11'h0, (k < wq.size()) ? wq[k].d : 16'h0, ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_len0();
        int cyc; logic b1;
        clear_mon();
        preload(1, 2);
        do_start(12'd0, 11'h055);
        wait_done(cyc, b1);
        repeat (3) @(negedge clk);
        n_checks++; if (cyc !== 1) begin n_fail++; $display("FAIL len0_done_cycle got %0d want 1", cyc); end
        n_checks++; if (wq.size() !== 0) begin n_fail++; $display("FAIL len0_writes got %0d want 0", wq.size()); end
        n_checks++; if (pop_cnt !== 0) begin n_fail++; $display("FAIL len0_pops got %0d want 0", pop_cnt); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy_after got %b want 0", ifc.busy); end
        fq.delete();
        refresh();
    endtask

    task automatic test_wrap();
        int cyc; logic b1;
        logic [10:0] ea[2]; logic [15:0] ed[2];
        ea[0] = 11'h7FF; ed[0] = 16'hCBA9;
        ea[1] = 11'h000; ed[1] = 16'h0FED;
        clear_mon();
        preload(9, 8);
        do_start(12'd2, 11'h7FF);
        wait_done(cyc, b1);
        n_checks++; if (cyc !== 11) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want 11", cyc); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (k >= wq.size() || wq[k].a !== ea[k] || wq[k].d !== ed[k]) begin
                n_fail++;
                $display("FAIL wrap_write%0d got addr %h data %h want addr %h data %h",
                         k, (k < wq.size()) ? wq[k].a : 11'h0, (k < wq.size()) ? wq[k].d : 16'h0, ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc; int seen; logic b1;
        clear_mon();
        preload(1, 4);
        do_start(12'd1, 11'h030);
        seen = 0;
        for (int i = 0; i < 50 && seen < 2; i++) begin
            @(negedge clk);
            if (ifc.fifo_rd) seen++;
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        fq.delete();
        refresh();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (seen !== 2) begin n_fail++; $display("FAIL rmid_pops_before got %0d want 2", seen); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", ifc.busy); end
        n_checks++; if (ifc.mem_d !== 16'h0) begin n_fail++; $display("FAIL rmid_mem_d got %h want 0", ifc.mem_d); end
        n_checks++; if (wq.size() !== 0) begin n_fail++; $display("FAIL rmid_writes got %0d want 0", wq.size()); end
        clear_mon();
        preload(10, 4);
        do_start(12'd1, 11'h030);
        wait_done(cyc, b1);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL rmid_restart_done got %0d want 6", cyc); end
        n_checks++;
        if (wq.size() != 1 || wq[0].a !== 11'h030 || wq[0].d !== 16'hDCBA) begin
            n_fail++;
            $display("FAIL rmid_restart_write got count %0d addr %h data %h want 1 030 dcba",
                     wq.size(), (wq.size() > 0) ? wq[0].a : 11'h0, (wq.size() > 0) ? wq[0].d : 16'h0);
        end
    endtask

    task automatic test_relu();
        int cyc; logic b1;
        logic [15:0] exp_d;
`ifdef FIFO_DRAIN_RELU_EN
        exp_d = 16'h7050;
`else
        exp_d = 16'h785D;
`endif
        clear_mon();
        fq.push_back(4'hD);
        fq.push_back(4'h5);
        fq.push_back(4'h8);
        fq.push_back(4'h7);
        refresh();
        do_start(12'd1, 11'h040);
        wait_done(cyc, b1);
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL relu_done_cycle got %0d want 6", cyc); end
        n_checks++;
        if (wq.size() != 1 || wq[0].a !== 11'h040 || wq[0].d !== exp_d) begin
            n_fail++;
            $display("FAIL relu_write got count %0d addr %h data %h want 1 040 %h",
                     wq.size(), (wq.size() > 0) ? wq[0].a : 11'h0, (wq.size() > 0) ? wq[0].d : 16'h0, exp_d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        ifc.start     = 1'b0;
        ifc.len       = '0;
        ifc.base_addr = '0;
        refresh();
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_wrap();
        test_reset_mid();
        test_relu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
